// File: rtl/ex_muldiv_if.sv
// Handshake/operand bundle between the ID/EX pipeline register and the
// iterative RV32M multiply/divide unit.
interface ex_muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_MD;
  logic [2:0]      op_MD;
  logic [XLEN-1:0] Rs1_in_MD;
  logic [XLEN-1:0] Rs2_in_MD;
  logic            flush_MD;
  logic            stall_MD;
  logic            busy_MD;
  logic            done_MD;
  logic [XLEN-1:0] result_out_MD;

  modport master (
    output start_MD, op_MD, Rs1_in_MD, Rs2_in_MD, flush_MD,
    input  stall_MD, busy_MD, done_MD, result_out_MD
  );

  modport slave (
    input  start_MD, op_MD, Rs1_in_MD, Rs2_in_MD, flush_MD,
    output stall_MD, busy_MD, done_MD, result_out_MD
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage (shift-add multiply,
// restoring divide). Define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
module ex_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic       clk_MD,
  input  logic       rst_MD,
  ex_muldiv_if.slave mdif
);
  localparam int unsigned     CW      = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic            is_div, sgn1, sgn2, neg_in;
  logic [XLEN-1:0] mag1, mag2;

  always_comb begin
    is_div = mdif.op_MD[2];
    sgn1   = mdif.Rs1_in_MD[XLEN-1] &
             (is_div ? ~mdif.op_MD[0] : (mdif.op_MD[1:0] != 2'b11));
    sgn2   = mdif.Rs2_in_MD[XLEN-1] &
             (is_div ? ~mdif.op_MD[0] : ~mdif.op_MD[1]);
    mag1   = sgn1 ? (~mdif.Rs1_in_MD + 1'b1) : mdif.Rs1_in_MD;
    mag2   = sgn2 ? (~mdif.Rs2_in_MD + 1'b1) : mdif.Rs2_in_MD;
    // Remainder takes the dividend's sign; everything else is sign1 ^ sign2.
    neg_in = (is_div & mdif.op_MD[1]) ? sgn1 : (sgn1 ^ sgn2);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  always_comb begin
    fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
  end
`endif

  // hi/lo is the running product for MUL*, remainder/quotient for DIV*.
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, dvs_q};
    if (!op_q[2]) begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      step_hi = div_diff[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      step_hi = div_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  function automatic logic [XLEN-1:0] finalize(input logic [2:0]      op,
                                               input logic            neg,
                                               input logic [XLEN-1:0] hi,
                                               input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   v;
    logic [XLEN-1:0]   r;
    p = {hi, lo};
    if (neg) p = ~p + 1'b1;
    v = op[1] ? hi : lo;
    if (neg) v = ~v + 1'b1;
    if (!op[2]) r = (op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    else        r = v;
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    op_d    = op_q;
    neg_d   = neg_q;
    res_d   = res_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mdif.start_MD && !mdif.flush_MD) begin
          op_d  = mdif.op_MD;
          neg_d = neg_in;
          if (is_div && mdif.Rs2_in_MD == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            res_d   = mdif.op_MD[1] ? mdif.Rs1_in_MD : '1;
          end else if (is_div && !mdif.op_MD[0] &&
                       mdif.Rs1_in_MD == INT_MIN && mdif.Rs2_in_MD == '1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            res_d   = mdif.op_MD[1] ? '0 : INT_MIN;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            res_d   = finalize(mdif.op_MD, neg_in,
                               fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0]);
          end
`endif
          else begin
            state_d = S_CALC;
            cnt_d   = CW'(XLEN);
            hi_d    = '0;
            lo_d    = is_div ? mag1 : mag2;
            dvs_d   = is_div ? mag2 : mag1;
          end
        end
      end
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          res_d   = finalize(op_q, neg_q, step_hi, step_lo);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (mdif.flush_MD) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      res_d   = res_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_MD) begin
    if (rst_MD) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign mdif.stall_MD      = ~rst_MD & mdif.start_MD & ~mdif.flush_MD &
                              (state_q != S_DONE);
  assign mdif.busy_MD       = busy_q;
  assign mdif.done_MD       = done_q;
  assign mdif.result_out_MD = res_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed + scoreboard bench for ex_muldiv: results, stall length, done
// latency, flush/reset aborts and back-to-back issue.
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32)) dif ();
  ex_muldiv #(.XLEN(32)) dut (.clk_MD(clk), .rst_MD(rst), .mdif(dif));

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  int          ncmp = 0;
  int          nerr = 0;
  int          ndone = 0;
  int          nops = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res = 32'h0;

  always @(negedge clk) if (!rst && dif.done_MD === 1'b1) ndone++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb64, su;
    logic [63:0]        p;
    int                 ia, ib;
    sa   = $signed({{32{a[31]}}, a});
    sb64 = $signed({{32{b[31]}}, b});
    su   = $signed({32'h0, b});
    ia   = a;
    ib   = b;
    case (op)
      3'b000: begin p = sa * sb64; return p[31:0]; end
      3'b001: begin p = sa * sb64; return p[63:32]; end
      3'b010: begin p = sa * su; return p[63:32]; end
      3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Entered and left at posedge+1; start stays high so consecutive calls issue back-to-back.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int          nst;
    int          cyc;
    logic        got;
    logic [31:0] e;
    sb.push_back(exp);
    nops++;
    dif.start_MD  = 1'b1;
    dif.op_MD     = op;
    dif.Rs1_in_MD = a;
    dif.Rs2_in_MD = b;
    nst = 0;
    cyc = 0;
    got = 1'b0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(negedge clk);
      if (dif.stall_MD === 1'b1) nst++;
      if (dif.done_MD === 1'b1) begin
        got = 1'b1;
        cyc = c;
      end
    end
    if (!got) begin
      chk({tag, "_timeout"}, 32'h0, 32'h1);
      void'(sb.pop_front());
    end else begin
      e = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      chk({tag, "_result"}, dif.result_out_MD, e);
      chk({tag, "_stall_cycles"}, nst, lat);
      chk({tag, "_done_cycle"}, cyc, lat + 1);
      last_res = e;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    dif.start_MD = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_stall", dif.stall_MD, 32'h0);
      chk("idle_done", dif.done_MD, 32'h0);
      chk("idle_hold", dif.result_out_MD, last_res);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    dif.start_MD  = 1'b0;
    dif.op_MD     = 3'b000;
    dif.Rs1_in_MD = 32'h0;
    dif.Rs2_in_MD = 32'h0;
    dif.flush_MD  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    dif.start_MD  = 1'b1;
    dif.op_MD     = 3'b100;
    dif.Rs1_in_MD = 32'd5;
    @(negedge clk);
    chk("rst_stall", dif.stall_MD, 32'h0);
    chk("rst_result", dif.result_out_MD, 32'h0);
    chk("rst_done", dif.done_MD, 32'h0);
    chk("rst_busy", dif.busy_MD, 32'h0);
    @(posedge clk); #1;
    dif.start_MD = 1'b0;
    rst = 1'b0;
    idle(2);

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    idle(2);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
    run_op("mulhsu", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT);
    run_op("mulhu",  3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, MUL_LAT);
    idle(1);
    run_op("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    idle(1);
    run_op("div_by0",  3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_by0",  3'b110, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    run_op("divu_by0", 3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", 3'b111, 32'd9, 32'd0, 32'd9, 1);
    run_op("divu_ovfpat", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33);
    idle(1);

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      run_op("rand", rop, ra, rb, model(rop, ra, rb), lat_of(rop, ra, rb));
    end
    idle(1);

    // Flush during CALC with start still asserted.
    dif.start_MD  = 1'b1;
    dif.op_MD     = 3'b101;
    dif.Rs1_in_MD = 32'h1234_5678;
    dif.Rs2_in_MD = 32'd3;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk("flush_pre_stall", dif.stall_MD, 32'h1);
      @(posedge clk); #1;
    end
    dif.flush_MD = 1'b1;
    @(negedge clk);
    chk("flush_stall", dif.stall_MD, 32'h0);
    chk("flush_busy_pre", dif.busy_MD, 32'h1);
    @(posedge clk); #1;
    dif.flush_MD = 1'b0;
    dif.start_MD = 1'b0;
    @(negedge clk);
    chk("flush_busy", dif.busy_MD, 32'h0);
    @(posedge clk); #1;
    idle(40);

    // Reset during CALC.
    dif.start_MD = 1'b1;
    dif.op_MD    = 3'b000;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_stall", dif.stall_MD, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    dif.start_MD = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", dif.busy_MD, 32'h0);
    chk("rst_mid_result", dif.result_out_MD, 32'h0);
    last_res = 32'h0;
    @(posedge clk); #1;
    idle(40);

    run_op("b2b_divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("b2b_mul",  3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    idle(3);

    chk("done_pulses", ndone, nops);
    chk("sb_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
